// File: rtl/program_loader.sv
// Boot-time loader: decodes a header/payload word stream into IMEM and DMEM
// write strobes, then enables the cpu for a commanded number of cycles.
module program_loader #(
    parameter int unsigned IMEM_DEPTH = 512,
    parameter int unsigned DMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        arst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD_I    = 3'd1;
    localparam logic [2:0] S_LOAD_D_LO = 3'd2;
    localparam logic [2:0] S_LOAD_D_HI = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_ERR       = 3'd5;

    localparam logic [1:0] CMD_IMEM = 2'b00;
    localparam logic [1:0] CMD_DMEM = 2'b01;
    localparam logic [1:0] CMD_RUN  = 2'b10;

    logic [2:0]  state;
    logic [13:0] off;
    logic [15:0] cnt_n;
    logic [15:0] k;
    logic [15:0] run_rem;
    logic [31:0] lo;

    logic        accept;
    logic        last_word;
    logic [1:0]  hdr_cmd;
    logic [13:0] hdr_off;
    logic [15:0] hdr_n;
    logic        range_i_bad;
    logic        range_d_bad;
    logic [63:0] word_addr;

    assign hdr_cmd = in_data[31:30];
    assign hdr_off = in_data[29:16];
    assign hdr_n   = in_data[15:0];

    // Ready is forced low while reset is held so no beat can be taken mid-reset.
    assign in_ready = !arst && (state == S_IDLE || state == S_LOAD_I ||
                                state == S_LOAD_D_LO || state == S_LOAD_D_HI);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != S_IDLE);
    assign error    = (state == S_ERR);

    assign range_i_bad = (32'(hdr_off) + 32'(hdr_n)) > IMEM_DEPTH;
    assign range_d_bad = (32'(hdr_off) + 32'(hdr_n)) > DMEM_DEPTH;
    assign word_addr   = 64'(off) + 64'(k);
    assign last_word   = (k == cnt_n - 16'd1);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            // NOTE: every register, including the address/data holding
            // registers and the lo latch, is reset; there is no memory array here.
            state       <= S_IDLE;
            off         <= '0;
            cnt_n       <= '0;
            k           <= '0;
            run_rem     <= '0;
            lo          <= '0;
            addr_ext    <= '0;
            wen_ext     <= 1'b0;
            wdata_ext   <= '0;
            addr_ext_2  <= '0;
            wen_ext_2   <= 1'b0;
            wdata_ext_2 <= '0;
            cpu_enable  <= 1'b0;
            done        <= 1'b0;
        end else begin
            wen_ext   <= 1'b0;
            wen_ext_2 <= 1'b0;
            done      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        off   <= hdr_off;
                        cnt_n <= hdr_n;
                        k     <= '0;
                        case (hdr_cmd)
                            CMD_IMEM: begin
                                if (hdr_n == 16'd0)  state <= S_IDLE;
                                else if (range_i_bad) state <= S_ERR;
                                else                  state <= S_LOAD_I;
                            end
                            CMD_DMEM: begin
                                if (hdr_n == 16'd0)  state <= S_IDLE;
                                else if (range_d_bad) state <= S_ERR;
                                else                  state <= S_LOAD_D_LO;
                            end
                            CMD_RUN: begin
                                state      <= S_RUN;
                                cpu_enable <= 1'b1;
                                run_rem    <= hdr_n;
                            end
                            default: state <= S_ERR;
                        endcase
                    end
                end

                S_LOAD_I: begin
                    if (accept) begin
                        wen_ext   <= 1'b1;
                        addr_ext  <= {word_addr[61:0], 2'b00};
                        wdata_ext <= in_data;
                        k         <= k + 16'd1;
                        if (last_word) state <= S_IDLE;
                    end
                end

                S_LOAD_D_LO: begin
                    if (accept) begin
                        lo    <= in_data;
                        state <= S_LOAD_D_HI;
                    end
                end

                S_LOAD_D_HI: begin
                    if (accept) begin
                        wen_ext_2   <= 1'b1;
                        addr_ext_2  <= {word_addr[60:0], 3'b000};
                        wdata_ext_2 <= {in_data, lo};
                        k           <= k + 16'd1;
                        state       <= last_word ? S_IDLE : S_LOAD_D_LO;
                    end
                end

                S_RUN: begin
                    // A zero count never decrements, so the cpu runs until reset.
                    if (run_rem == 16'd1) begin
                        cpu_enable <= 1'b0;
                        done       <= 1'b1;
                        run_rem    <= '0;
                        state      <= S_IDLE;
                    end else if (run_rem != 16'd0) begin
                        run_rem <= run_rem - 16'd1;
                    end
                end

                S_ERR: begin
                    cpu_enable <= 1'b0;
                end

                default: state <= S_ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected strobe events
// (kind, address, data, cycle); a negedge monitor pops and compares them.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic [63:0] wdata_ext_2;
    logic        cpu_enable;
    logic        busy;
    logic        done;
    logic        error;

    program_loader dut (
        .clk         (clk),
        .arst        (arst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .cpu_enable  (cpu_enable),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_IMEM, EV_DMEM, EV_EN, EV_DONE} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [63:0] addr;
        logic [63:0] data;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void expect_ev(ev_kind_e k, logic [63:0] a, logic [63:0] d, int c);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endfunction

    // Monitor: every strobe / enable / done cycle must match the queue head.
    always @(negedge clk) begin : monitor
        int  hits;
        ev_t obs;
        ev_t e;
        if (!arst) begin
            hits = int'(wen_ext) + int'(wen_ext_2) + int'(cpu_enable) + int'(done);
            if (hits != 0) begin
                check("strobe_exclusive", 64'(hits), 64'd1);
                obs.kind = wen_ext ? EV_IMEM : wen_ext_2 ? EV_DMEM : cpu_enable ? EV_EN : EV_DONE;
                obs.addr = wen_ext ? addr_ext : wen_ext_2 ? addr_ext_2 : 64'd0;
                obs.data = wen_ext ? {32'd0, wdata_ext} : wen_ext_2 ? wdata_ext_2 : 64'd0;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none",
                             obs.kind, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", 64'(obs.kind), 64'(e.kind));
                    check("event_cycle", 64'(cyc), 64'(e.cyc));
                    check("event_addr", obs.addr, e.addr);
                    check("event_data", obs.data, e.data);
                end
            end
        end
    end

    // Called at a negedge; returns (valid still high) once in_ready is seen,
    // with the cycle number the beat will be accepted on.
    task automatic send(input logic [31:0] d, output int acc);
        acc      = -1;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                acc = cyc + 1;
                return;
            end
            @(negedge clk);
        end
        n_vec++;
        n_bad++;
        $display("FAIL send_timeout: in_ready stayed 0 for beat 0x%08h, expected 1", d);
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        #1 arst = 1'b1;
        @(negedge clk);
        check("rst_flags", {in_ready, busy, error, cpu_enable, done, wen_ext, wen_ext_2}, 64'd0);
        check("rst_imem_addr", addr_ext, 64'd0);
        check("rst_imem_data", 64'(wdata_ext), 64'd0);
        check("rst_dmem_addr", addr_ext_2, 64'd0);
        check("rst_dmem_data", wdata_ext_2, 64'd0);
        #1 arst = 1'b0;
        @(negedge clk);
        check("post_rst_ready_busy_err", {in_ready, busy, error}, 64'b100);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        int h, h1, a;

        repeat (2) @(negedge clk);
        check("init_rst_flags", {in_ready, busy, error, cpu_enable, done, wen_ext, wen_ext_2}, 64'd0);
        #1 arst = 1'b0;
        @(negedge clk);
        check("init_ready", {in_ready, busy, error}, 64'b100);

        // IMEM load: OFF=2, N=3, back-to-back beats.
        send(32'h0002_0003, h); step();
        send(32'hA0A0_0001, a); expect_ev(EV_IMEM, 64'h8,  64'hA0A0_0001, a); step();
        send(32'hB0B0_0002, a); expect_ev(EV_IMEM, 64'hC,  64'hB0B0_0002, a); step();
        send(32'hC0C0_0003, a); expect_ev(EV_IMEM, 64'h10, 64'hC0C0_0003, a); step();
        check("imem_busy_after", 64'(busy), 64'd0);

        // DMEM load with a 2-cycle gap between the halves.
        send(32'h4000_0001, h); step();
        send(32'h1111_1111, a); step();
        repeat (2) @(negedge clk);
        check("dmem_busy_in_gap", 64'(busy), 64'd1);
        send(32'h2222_2222, a); expect_ev(EV_DMEM, 64'h0, 64'h2222_2222_1111_1111, a); step();
        check("dmem_busy_after", 64'(busy), 64'd0);

        // RUN for 5 cycles, done on the 6th.
        send(32'h8000_0005, h);
        for (int i = 0; i < 5; i++) expect_ev(EV_EN, 64'd0, 64'd0, h + i);
        expect_ev(EV_DONE, 64'd0, 64'd0, h + 5);
        step();
        for (int i = 0; i < 5; i++) begin
            check("run_ready_low", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        check("run_ready_after_done", 64'(in_ready), 64'd1);

        // Zero-count header, next header accepted the very next cycle.
        send(32'h0000_0000, h); step();
        send(32'h0010_0001, h1);
        check("zero_next_hdr_cycle", 64'(h1), 64'(h + 1));
        step();
        send(32'hDEAD_BEEF, a); expect_ev(EV_IMEM, 64'h40, 64'hDEAD_BEEF, a); step();

        // Reset after the low DMEM beat discards the partial word.
        send(32'h4000_0001, h); step();
        send(32'h3333_3333, a); step();
        reset_pulse();
        send(32'h4003_0002, h); step();
        send(32'h5555_5555, a); step();
        send(32'h6666_6666, a); expect_ev(EV_DMEM, 64'h18, 64'h6666_6666_5555_5555, a); step();
        send(32'h7777_7777, a); step();
        send(32'h8888_8888, a); expect_ev(EV_DMEM, 64'h20, 64'h8888_8888_7777_7777, a); step();

        // RUN with N=0 runs until reset.
        send(32'h8000_0000, h);
        for (int i = 0; i < 10; i++) expect_ev(EV_EN, 64'd0, 64'd0, h + i);
        step();
        repeat (9) @(negedge clk);
        reset_pulse();

        // Range error: OFF=511, N=2 overruns IMEM.
        send(32'h01FF_0002, h); step();
        check("range_err_flags", {error, in_ready, busy}, 64'b101);
        repeat (3) @(negedge clk);
        check("range_err_sticky", {error, cpu_enable}, 64'b10);
        reset_pulse();

        // Illegal command.
        send(32'hC000_0000, h); step();
        check("illegal_cmd_err", {error, in_ready}, 64'b10);
        reset_pulse();

        // Last legal IMEM and DMEM words.
        send(32'h01FF_0001, h); step();
        send(32'h1234_5678, a); expect_ev(EV_IMEM, 64'h7FC, 64'h1234_5678, a); step();
        check("imem_edge_no_err", 64'(error), 64'd0);
        send(32'h43FF_0001, h); step();
        send(32'h9ABC_DEF0, a); step();
        send(32'h0FED_CBA9, a); expect_ev(EV_DMEM, 64'h1FF8, 64'h0FED_CBA9_9ABC_DEF0, a); step();
        check("dmem_edge_no_err", 64'(error), 64'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
